// File: rtl/syncfifo_flex.sv
// Single-clock FIFO with occupancy count, programmable almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and an optional FWFT read port.
module syncfifo_flex #(
   parameter int FIFO_DEPTH      = 8,
   parameter int DATA_WIDTH      = 32,
   parameter int ALMOST_FULL_TH  = 6,
   parameter int ALMOST_EMPTY_TH = 2,
   parameter int FWFT            = 0
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          cs,
   input  logic                          wr_en,
   input  logic                          rd_en,
   input  logic                          clr_err,
   input  logic [DATA_WIDTH-1:0]         data_in,
   output logic [DATA_WIDTH-1:0]         data_out,
   output logic                          empty,
   output logic                          full,
   output logic                          almost_empty,
   output logic                          almost_full,
   output logic [$clog2(FIFO_DEPTH):0]   count,
   output logic                          overflow,
   output logic                          underflow
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]         r_wr_ptr;
   logic [AW-1:0]         r_rd_ptr;
   logic [CW-1:0]         r_count;
   logic                  r_overflow;
   logic                  r_underflow;

   logic w_empty;
   logic w_full;
   logic w_wa;
   logic w_ra;

   // Handshake: with cs=1, wr_en pushes data_in unless full and rd_en pops the
   // head unless empty; both decisions use the occupancy registered at the
   // start of the cycle, so a full FIFO never accepts a write even while it is
   // being read. A refused request only raises the matching sticky flag.
   assign w_empty = (r_count == '0);
   assign w_full  = (r_count == CW'(FIFO_DEPTH));
   assign w_wa    = cs & wr_en & ~w_full;
   assign w_ra    = cs & rd_en & ~w_empty;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_wa) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_ra) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_wa, w_ra})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Storage is left uncleared on reset; the pointers make old contents unreachable.
   always_ff @(posedge clk) begin
      if (!rst && w_wa) r_mem[r_wr_ptr] <= data_in;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else if (cs) begin
         if (wr_en && w_full)  r_overflow <= 1'b1;
         else if (clr_err)     r_overflow <= 1'b0;
         if (rd_en && w_empty) r_underflow <= 1'b1;
         else if (clr_err)     r_underflow <= 1'b0;
      end
   end

   generate
      if (FWFT != 0) begin : g_fwft
         // Head word is presented directly; forced to zero while nothing is stored.
         assign data_out = w_empty ? '0 : r_mem[r_rd_ptr];
      end else begin : g_std
         logic [DATA_WIDTH-1:0] r_data_out;
         always_ff @(posedge clk) begin
            if (rst)       r_data_out <= '0;
            else if (w_ra) r_data_out <= r_mem[r_rd_ptr];
         end
         assign data_out = r_data_out;
      end
   endgenerate

   assign empty        = w_empty;
   assign full         = w_full;
   assign almost_empty = (r_count <= CW'(ALMOST_EMPTY_TH));
   assign almost_full  = (r_count >= CW'(ALMOST_FULL_TH));
   assign count        = r_count;
   assign overflow     = r_overflow;
   assign underflow    = r_underflow;

endmodule

// File: doc/syncfifo_flex.md
Name: syncfifo_flex

Overview:
- Second-generation single-clock FIFO. Successor to the basic synchronous FIFO.
- Adds an occupancy count and programmable almost-full / almost-empty thresholds.
- Adds sticky overflow / underflow error flags and an optional first-word-fall-through (FWFT) read mode.
- Drop-in buffer between producer/consumer blocks on one clock domain; keeps the cs/wr_en/rd_en handshake of the earlier FIFO.

Parameters:
- FIFO_DEPTH, 8, number of entries; power of two, >= 2
- DATA_WIDTH, 32, data word width in bits
- ALMOST_FULL_TH, 6, almost_full asserts when count >= this; range 1..FIFO_DEPTH
- ALMOST_EMPTY_TH, 2, almost_empty asserts when count <= this; range 0..FIFO_DEPTH-1
- FWFT, 0, 0 = registered read data (standard); 1 = first-word-fall-through

Ports:
- clk  in  1  clock; all logic on rising edge
- rst  in  1  synchronous active-high reset
- cs  in  1  chip select; gates wr_en, rd_en and clr_err
- wr_en  in  1  write request
- rd_en  in  1  read request
- clr_err  in  1  clears overflow/underflow when cs=1
- data_in  in  DATA_WIDTH  write data
- data_out  out  DATA_WIDTH  read data
- empty  out  1  count == 0
- full  out  1  count == FIFO_DEPTH
- almost_empty  out  1  count <= ALMOST_EMPTY_TH
- almost_full  out  1  count >= ALMOST_FULL_TH
- count  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH
- overflow  out  1  sticky: a write was attempted while full
- underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Clock and reset: single clock clk; reset rst is synchronous and active-high.
- Reset values (sampled at the clk edge with rst=1): wr/rd pointers 0, count 0, empty 1, full 0, almost_empty 1, almost_full 0, overflow 0, underflow 0, data_out 0. Memory contents need not be cleared.
- Reset mid-operation: all stored data is discarded. The first cycle after rst deasserts behaves exactly as after power-up reset.
- Accepted write (wa) = cs & wr_en & !full. Stores data_in at wr_ptr; wr_ptr increments modulo FIFO_DEPTH.
- Accepted read (ra) = cs & rd_en & !empty. rd_ptr increments modulo FIFO_DEPTH.
- Full/empty tests use the registered state at the start of the cycle; there is no same-cycle bypass.
- Count update: +1 when wa & !ra, -1 when ra & !wa, unchanged when both or neither.
- Simultaneous rd/wr: when 0 < count < FIFO_DEPTH, both are accepted and count is unchanged.
  - When full: the read is accepted and the write is rejected; overflow sets.
  - When empty: the write is accepted and the read is rejected; underflow sets.
- Error flags:
  - overflow sets on cs & wr_en & full. underflow sets on cs & rd_en & empty.
  - Both clear only on rst, or on cs & clr_err. Set has priority over clear in the same cycle.
  - Rejected operations change no pointer, count or data.
- cs=0: no operation and no flag changes, regardless of wr_en/rd_en.
- Status outputs: empty, full, almost_* and count are registered, or decoded purely from registered count. They update the cycle after the causing edge and have no combinational path from inputs.
- Standard mode (FWFT=0):
  - On ra, data_out <= mem[rd_ptr] at the same edge; read latency is 1 clock.
  - data_out holds its value when no read is accepted.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr], valid whenever empty=0; ra pops it.
  - The first write into an empty FIFO is visible on data_out, with empty=0, one cycle after the write edge.
  - data_out is don't-care while empty; the bench must not check it.
- Wrap-around: pointers wrap FIFO_DEPTH-1 -> 0 with no data corruption. Ordering is strictly first-in, first-out.

Test Plan:
- Reset: drive rst=1 for 2 cycles with wr_en=1 -> count=0, empty=1, full=0, almost_empty=1, overflow=underflow=0, data_out=0.
- Basic order (FWFT=0): write 1, 10, 100 then read 3 times -> data_out 1, 10, 100, each one clock after its read edge; count steps 1,2,3,2,1,0; empty=1 at end.
- Fill/overflow: write 2**i for i=0..8 (9 writes) -> full=1 after 8 writes; the 9th is rejected and overflow=1. Reading 8 words returns 1..128 in order, then empty=1. A further read sets underflow=1. cs=1 & clr_err=1 clears both.
- Thresholds (AF=6, AE=2): fill count 0->8 -> almost_empty deasserts at count 3, almost_full asserts at count 6. Mirror on drain.
- Simultaneous: at count=3, wr_en=rd_en=1 for 10 cycles with incrementing data (pointers wrap) -> count stays 3, output order intact. Same at full and at empty -> behaviour as specified, with the matching error flag set.
- FWFT=1 instance: write 0xA5 -> next cycle empty=0, data_out=0xA5 with no read. Read -> empty=1. Then assert rst after 4 writes -> count=0, empty=1, and the next write/read returns only post-reset data.
